sar_oversample_seq: RTL and testbench

Conversion sequencer and oversampling averager for the SAR ADC datapath. It sits directly upstream of the SAR binary-search FSM, which it commands through `start`, and directly downstream of it, consuming `result` and `eoc`. It issues 2^Log2Samples back-to-back conversions, sums the results, and presents the truncated mean with a one-cycle valid strobe. Optionally, a watchdog aborts a conversion whose `eoc` never arrives.

---
 rtl/sar_oversample_seq.sv | 117 +++++++++++
 tb/tb_sar_oversample_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sar_oversample_seq.sv
// Conversion sequencer + oversampling averager around the SAR binary-search FSM.
// Optional watchdog on a lost eoc is built when SAR_SEQ_TIMEOUT_EN is defined.
module sar_oversample_seq #(
    parameter int Width         = 6,
    parameter int Log2Samples   = 2,
    parameter int TimeoutCycles = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] result_i,
    input  logic             eoc_i,
    output logic             start_o,
    output logic [Width-1:0] avg_o,
    output logic             avg_valid_o,
    output logic             busy_o,
    output logic             timeout_o
);
    localparam int AccW = Width + Log2Samples;
    localparam int CntW = (Log2Samples > 0) ? Log2Samples : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << Log2Samples) - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          state;
    logic [AccW-1:0] acc;
    logic [CntW-1:0] cnt;
    logic [AccW-1:0] sum;

    // Running sum including the sample arriving this cycle; sized so it cannot wrap.
    assign sum = acc + AccW'(result_i);

`ifdef SAR_SEQ_TIMEOUT_EN
    localparam int WdW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);
    logic [WdW-1:0] wd;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            start_o     <= 1'b0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
            busy_o      <= 1'b0;
`ifdef SAR_SEQ_TIMEOUT_EN
            wd          <= '0;
            timeout_o   <= 1'b0;
`endif
        end else begin
            start_o     <= 1'b0;
            avg_valid_o <= 1'b0;
`ifdef SAR_SEQ_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (en_i) begin
                        state   <= START;
                        start_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef SAR_SEQ_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                WAIT: begin
                    if (eoc_i) begin
                        if (cnt == CntLast) begin
                            // Average is registered on entry so it is valid during DONE;
                            // the accumulator is cleared here rather than one cycle later.
                            state       <= DONE;
                            avg_o       <= sum[AccW-1:Log2Samples];
                            avg_valid_o <= 1'b1;
                            acc         <= '0;
                            cnt         <= '0;
                        end else begin
                            state   <= START;
                            start_o <= 1'b1;
                            acc     <= sum;
                            cnt     <= cnt + 1'b1;
                        end
                    end
`ifdef SAR_SEQ_TIMEOUT_EN
                    else if (wd == WdLast) begin
                        state     <= IDLE;
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        wd        <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (en_i) begin
                        state   <= START;
                        start_o <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_oversample_seq.sv
// Randomized bench for sar_oversample_seq against a phase-level reference model
// (averages computed as integer means of queued samples).
module tb_sar_oversample_seq;
    localparam int W = 6;
    localparam int L = 2;
    localparam int T = 16;
    localparam int N = 1 << L;

    logic         clk = 1'b0;
    logic         rst, en, eoc;
    logic [W-1:0] result;
    logic         start, avg_valid, busy, timeout;
    logic [W-1:0] avg;

    always #5 clk = ~clk;

    sar_oversample_seq #(.Width(W), .Log2Samples(L), .TimeoutCycles(T)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .result_i(result), .eoc_i(eoc),
        .start_o(start), .avg_o(avg), .avg_valid_o(avg_valid), .busy_o(busy),
        .timeout_o(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phases of a block, samples kept in a queue
    typedef enum {P_IDLE, P_START, P_WAIT, P_DONE} phase_t;
    phase_t ph = P_IDLE;
    int     q[$];
    int     m_avg = 0;
    int     wd = 0;
    bit     e_start = 0, e_valid = 0, e_to = 0;

    task automatic model_step();
        int s;
        e_start = 0; e_valid = 0; e_to = 0;
        if (rst) begin
            ph = P_IDLE; q.delete(); m_avg = 0; wd = 0;
            return;
        end
        case (ph)
            P_IDLE: if (en) begin ph = P_START; e_start = 1; end
            P_START: begin ph = P_WAIT; wd = 0; end
            P_WAIT: begin
                if (eoc) begin
                    q.push_back(int'(result));
                    if (q.size() == N) begin
                        s = 0;
                        foreach (q[i]) s += q[i];
                        m_avg = s / N;
                        e_valid = 1;
                        q.delete();
                        ph = P_DONE;
                    end else begin
                        ph = P_START; e_start = 1;
                    end
                end else begin
                    wd++;
`ifdef SAR_SEQ_TIMEOUT_EN
                    if (wd == T) begin e_to = 1; q.delete(); ph = P_IDLE; end
`endif
                end
            end
            P_DONE: begin
                if (en) begin ph = P_START; e_start = 1; end
                else ph = P_IDLE;
            end
        endcase
    endtask

    int n_start = 0, n_to = 0;

    task automatic compare();
        chk("start", start, e_start);
        chk("avg_valid", avg_valid, e_valid);
        chk("busy", busy, ph != P_IDLE);
        chk("timeout", timeout, e_to);
        chk("avg", avg, m_avg);
        if (start) n_start++;
        if (timeout) n_to++;
    endtask

    // SAR responder: answers each start_o after a random delay, plus stray strobes
    int cd = -1;
    int dly_min = 1, dly_max = 4;
    int rmode = 0, rfix = 0, stray_pct = 0;

    task automatic drive_next();
        eoc = 1'b0;
        result = W'($urandom);
        if (start) cd = $urandom_range(dly_max, dly_min);
        else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                eoc = 1'b1;
                cd = -1;
                if (rmode == 1) result = W'(rfix);
                else if (rmode == 2) begin result = W'(rfix); rfix++; end
            end
        end
        if (!eoc && $urandom_range(99, 0) < stray_pct) eoc = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        drive_next();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; eoc = 1'b0; result = '0;
        tick(); tick();

        // Single block: results 10..13, eoc 3 cycles after each start
        rst = 1'b0; rmode = 2; rfix = 10; dly_min = 3; dly_max = 3; n_start = 0;
        tick();
        en = 1'b0;
        repeat (30) tick();
        chk("single_starts", n_start, 4);
        chk("single_avg", avg, 11);
        chk("single_idle", busy, 0);

        // Continuous full-scale with fastest responder
        en = 1'b1; rmode = 1; rfix = 63; dly_min = 1; dly_max = 1;
        repeat (60) begin
            tick();
            if (avg_valid) chk("fullscale_avg", avg, 63);
        end

        // Stray strobes and en dropped mid-block
        rmode = 0; dly_min = 2; dly_max = 2; stray_pct = 30;
        repeat (10) tick();
        en = 1'b0;
        repeat (40) tick();
        stray_pct = 0;
        repeat (10) tick();
        chk("late_en_idle", busy, 0);

        // Withheld eoc; watchdog aborts only when it is built in
        dly_min = 30; dly_max = 30; n_to = 0;
        en = 1'b1; tick(); en = 1'b0;
        repeat (40) tick();
`ifdef SAR_SEQ_TIMEOUT_EN
        chk("wd_fired", n_to > 0, 1);
`else
        chk("wd_absent", n_to, 0);
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        dly_min = 1; dly_max = 3; rmode = 1; rfix = 37;
        en = 1'b1; tick(); en = 1'b0;
        repeat (30) tick();
        chk("after_wd_avg", avg, 37);

        // Reset after about two samples of a block
        rmode = 0; dly_min = 2; dly_max = 2;
        en = 1'b1; tick(); en = 1'b0;
        repeat (7) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        rmode = 1; rfix = 20; dly_min = 1; dly_max = 4;
        en = 1'b1; tick(); en = 1'b0;
        repeat (30) tick();
        chk("rst_block_avg", avg, 20);

        // Random soak
        rmode = 0; stray_pct = 10; dly_min = 1;
`ifdef SAR_SEQ_TIMEOUT_EN
        dly_max = 20;
`else
        dly_max = 6;
`endif
        repeat (3000) begin
            rst = ($urandom_range(299, 0) == 0);
            if ($urandom_range(99, 0) < 5) en = ~en;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
